eth_link_supervisor: RTL and testbench
======================================

Name: eth_link_supervisor

Overview:
- Sequences bring-up and recovery of one 10GBASE-R lane: the GT transceiver wizard, the 10G PCS/PHY and the 10G MAC.
- Drives the GT full reset and the RX-datapath reset, qualifies block lock, and publishes a debounced link-up to the MAC and host.
- Runs on the 125 MHz free-running clock. All status inputs are already synchronized into this domain by sync_reset or sync_signal instances outside this block.

Parameters:
- RESET_CYCLES, 1024: cycles gt_reset_all is held on each full reset.
- RX_RESET_CYCLES, 16: cycles gt_reset_rx_datapath is held on each RX reset.
- LOCK_TIMEOUT, 1250000: cycles allowed for reset-done or for block lock (10 ms).
- LINK_DEBOUNCE, 4096: consecutive cycles of lock with no high BER required before link up.
- MAX_RETRIES, 4: consecutive RX resets before escalating to a full reset; range 1..15.

Ports:
- clk  in  1  free-running 125 MHz clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  link enable; 0 forces and holds a full reset
- gt_reset_tx_done  in  1  GT TX reset complete
- gt_reset_rx_done  in  1  GT RX reset complete
- rx_block_lock  in  1  PCS block lock
- rx_high_ber  in  1  PCS high bit-error rate
- gt_reset_all  out  1  GT full reset
- gt_reset_rx_datapath  out  1  GT RX datapath reset
- link_up  out  1  qualified link status
- link_state  out  3  current FSM state encoding
- retry_count  out  4  consecutive RX resets since the last full reset
- link_down_events  out  16  saturating count of UP-to-down transitions

Behaviour:
- All outputs are registers, updated together with the state register. There is no combinational input-to-output path.
- Reset values:
  - state RESET (0)
  - gt_reset_all = 1
  - gt_reset_rx_datapath = 0
  - link_up = 0
  - retry_count = 0
  - link_down_events = 0
  - timer = 0
- One shared timer:
  - Width is clog2 of the largest parameter, plus 1.
  - Cleared on every state transition; increments otherwise.
- State RESET (0):
  - gt_reset_all = 1.
  - Exit when the timer reaches RESET_CYCLES-1 and enable = 1; go to WAIT_DONE.
  - gt_reset_all is therefore high for exactly RESET_CYCLES cycles after entry.
  - While enable = 0, stay in RESET with the timer held at 0.
- State WAIT_DONE (1):
  - gt_reset_all = 0.
  - When both done inputs are 1, go to WAIT_LOCK.
  - If the timer reaches LOCK_TIMEOUT-1 first, go to RESET and clear retry_count.
- State WAIT_LOCK (2):
  - The timer counts total time in the state.
  - A separate debounce counter increments while (rx_block_lock & ~rx_high_ber) and clears to 0 otherwise.
  - Debounce counter reaching LINK_DEBOUNCE-1 goes to UP. link_up = 1 from the first cycle of UP.
  - Timer reaching LOCK_TIMEOUT-1 goes to RX_RESET.
- State UP (3):
  - link_up = 1.
  - Exit on any of: rx_block_lock = 0, rx_high_ber = 1, or gt_reset_rx_done = 0.
  - On exit: link_up = 0 on the next cycle, link_down_events increments (holds at 0xFFFF), and retry_count clears.
  - Next state is WAIT_LOCK, or WAIT_DONE if gt_reset_rx_done = 0.
- State RX_RESET (4):
  - gt_reset_rx_datapath = 1 for exactly RX_RESET_CYCLES cycles.
  - Increment retry_count on entry.
  - Then go to WAIT_DONE. If retry_count has reached MAX_RETRIES, go to RESET instead and clear retry_count.
- A done input dropping in WAIT_LOCK goes to WAIT_DONE.
- enable = 0 in any state goes to RESET on the next cycle; link_up drops then. A drop from UP also counts as a link-down event.
- Simultaneous events, priority high to low: enable = 0, done loss, timeout, lock/debounce success.
- rst asserted mid-operation returns every register to its reset value immediately, asynchronously.
- Encodings 5..7 are unreachable; if entered, next state is RESET.

Test Plan:
Bench parameters: RESET_CYCLES=8, RX_RESET_CYCLES=4, LOCK_TIMEOUT=100, LINK_DEBOUNCE=10, MAX_RETRIES=2.
1. Clean bring-up: release rst with enable=1, done inputs high at cycle 20, lock high at cycle 30 -> gt_reset_all high exactly 8 cycles; link_up rises at cycle 30+10 exactly; link_state = 3.
2. Lock glitch during debounce: lock high 6 cycles, low 1 cycle, then high -> link_up only after 10 further consecutive cycles; no RX reset pulse.
3. No lock -> gt_reset_rx_datapath pulses (4 cycles each) reach retry_count=2, then a full reset (gt_reset_all 8 cycles) and retry_count=0.
4. Link drop in UP: drop rx_block_lock for 1 cycle -> link_up low next cycle, link_down_events=1, state WAIT_LOCK; repeat past 0xFFFF (forced) -> stays 0xFFFF.
5. enable deasserted in UP together with a high-BER event -> next state RESET; gt_reset_all held while enable=0; link_down_events increments once.
6. rst asserted mid-RX_RESET -> gt_reset_rx_datapath=0, gt_reset_all=1, counters 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/eth_link_supervisor.sv
// Bring-up / recovery sequencer for one 10GBASE-R lane: GT full reset, RX datapath
// reset, block-lock qualification and debounced link-up, all outputs registered.
module eth_link_supervisor #(
  parameter int RESET_CYCLES    = 1024,
  parameter int RX_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1250000,
  parameter int LINK_DEBOUNCE   = 4096,
  parameter int MAX_RETRIES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        gt_reset_tx_done,
  input  logic        gt_reset_rx_done,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  output logic        gt_reset_all,
  output logic        gt_reset_rx_datapath,
  output logic        link_up,
  output logic [2:0]  link_state,
  output logic [3:0]  retry_count,
  output logic [15:0] link_down_events
);
  localparam int MAX_A = (RESET_CYCLES > RX_RESET_CYCLES) ? RESET_CYCLES : RX_RESET_CYCLES;
  localparam int MAX_B = (LOCK_TIMEOUT > LINK_DEBOUNCE) ? LOCK_TIMEOUT : LINK_DEBOUNCE;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_UP        = 3'd3,
    S_RX_RESET  = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt, deb, deb_nxt;
  logic [3:0]     retry_nxt;
  logic [15:0]    lde_nxt;
  logic           done_ok, lock_ok;

  assign done_ok    = gt_reset_tx_done & gt_reset_rx_done;
  assign lock_ok    = rx_block_lock & ~rx_high_ber;
  assign link_state = state;

  always_comb begin
    state_nxt = state;
    deb_nxt   = '0;
    retry_nxt = retry_count;
    lde_nxt   = link_down_events;
    case (state)
      S_RESET:
        if (enable && timer == TW'(RESET_CYCLES - 1)) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (!enable)                                state_nxt = S_RESET;
        else if (timer == TW'(LOCK_TIMEOUT - 1))    state_nxt = S_RESET;
        else if (done_ok)                           state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (!enable)                                state_nxt = S_RESET;
        else if (!done_ok)                          state_nxt = S_WAIT_DONE;
        else if (timer == TW'(LOCK_TIMEOUT - 1))    state_nxt = S_RX_RESET;
        else if (lock_ok && deb == TW'(LINK_DEBOUNCE - 1)) state_nxt = S_UP;
        else if (lock_ok)                           deb_nxt   = deb + 1'b1;
      S_UP:
        if (!enable)                                state_nxt = S_RESET;
        else if (!gt_reset_rx_done)                 state_nxt = S_WAIT_DONE;
        else if (!lock_ok)                          state_nxt = S_WAIT_LOCK;
      S_RX_RESET:
        if (!enable)                                state_nxt = S_RESET;
        else if (timer == TW'(RX_RESET_CYCLES - 1))
          state_nxt = (retry_count >= 4'(MAX_RETRIES)) ? S_RESET : S_WAIT_DONE;
      default:                                      state_nxt = S_RESET;
    endcase

    // Retry bookkeeping: a full reset or a good link restarts the escalation count.
    if (state == S_UP && state_nxt != S_UP) begin
      retry_nxt = '0;
      if (link_down_events != 16'hFFFF) lde_nxt = link_down_events + 16'd1;
    end
    if (state_nxt == S_RX_RESET && state != S_RX_RESET && retry_count != 4'hF)
      retry_nxt = retry_count + 4'd1;
    if (state_nxt == S_RESET && state != S_RESET)
      retry_nxt = '0;

    if (state_nxt != state || (state == S_RESET && !enable)) timer_nxt = '0;
    else                                                      timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_RESET;
      timer                <= '0;
      deb                  <= '0;
      gt_reset_all         <= 1'b1;
      gt_reset_rx_datapath <= 1'b0;
      link_up              <= 1'b0;
      retry_count          <= '0;
      link_down_events     <= '0;
    end else begin
      state                <= state_nxt;
      timer                <= timer_nxt;
      deb                  <= deb_nxt;
      gt_reset_all         <= (state_nxt == S_RESET);
      gt_reset_rx_datapath <= (state_nxt == S_RX_RESET);
      link_up              <= (state_nxt == S_UP);
      retry_count          <= retry_nxt;
      link_down_events     <= lde_nxt;
    end
  end
endmodule

// File: tb/tb_eth_link_supervisor.sv
// Directed bench for eth_link_supervisor: expectations queued as stimulus is applied,
// then popped and checked against the DUT outputs.
module tb_eth_link_supervisor;
  logic        clk = 1'b0;
  logic        rst, enable, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber;
  logic        gt_reset_all, gt_reset_rx_datapath, link_up;
  logic [2:0]  link_state;
  logic [3:0]  retry_count;
  logic [15:0] link_down_events;

  eth_link_supervisor #(
    .RESET_CYCLES(8), .RX_RESET_CYCLES(4), .LOCK_TIMEOUT(100),
    .LINK_DEBOUNCE(10), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .gt_reset_tx_done(gt_reset_tx_done), .gt_reset_rx_done(gt_reset_rx_done),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .gt_reset_all(gt_reset_all), .gt_reset_rx_datapath(gt_reset_rx_datapath),
    .link_up(link_up), .link_state(link_state), .retry_count(retry_count),
    .link_down_events(link_down_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } item_t;

  item_t q[$];
  int    total = 0, passed = 0, fails = 0;
  int    meas = 0, rx_hi = 0, base = 0;

  always @(negedge clk) if (gt_reset_rx_datapath === 1'b1) rx_hi++;

  function automatic logic [15:0] obs(int sel);
    case (sel)
      0: obs = {15'd0, gt_reset_all};
      1: obs = {15'd0, gt_reset_rx_datapath};
      2: obs = {15'd0, link_up};
      3: obs = {13'd0, link_state};
      4: obs = {12'd0, retry_count};
      5: obs = link_down_events;
      default: obs = meas[15:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_(string tag, int sel, logic [15:0] exp);
    q.push_back('{tag, sel, exp});
  endtask

  task automatic check_q();
    while (q.size() > 0) begin
      item_t       it;
      logic [15:0] o;
      it = q.pop_front();
      o  = obs(it.sel);
      total++;
      assert (o === it.exp) passed++;
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic wait_for(string tag, int sel, logic [15:0] val, int bound);
    int n = 0;
    while (obs(sel) !== val && n < bound) begin
      tick();
      n++;
    end
    expect_(tag, sel, val);
    check_q();
  endtask

  // Width of a high pulse starting at the current sample point.
  task automatic measure(string tag, int sel, int width);
    meas = 0;
    while (obs(sel) === 16'd1 && meas < 200) begin
      meas++;
      tick();
    end
    expect_(tag, 9, 16'(width));
    check_q();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; gt_reset_tx_done = 1'b0; gt_reset_rx_done = 1'b0;
    rx_block_lock = 1'b0; rx_high_ber = 1'b0;
    #12;
    expect_("rst_gt_reset_all", 0, 16'd1);
    expect_("rst_rx_dp", 1, 16'd0);
    expect_("rst_link_up", 2, 16'd0);
    expect_("rst_state", 3, 16'd0);
    expect_("rst_retry", 4, 16'd0);
    expect_("rst_lde", 5, 16'd0);
    check_q();

    // 1. clean bring-up
    tick();
    rst = 1'b0;
    measure("bringup_reset_width", 0, 8);
    expect_("bringup_wait_done", 3, 16'd1);
    check_q();
    gt_reset_tx_done = 1'b1; gt_reset_rx_done = 1'b1;
    tick();
    expect_("bringup_wait_lock", 3, 16'd2);
    check_q();
    rx_block_lock = 1'b1;
    repeat (9) tick();
    expect_("bringup_link_not_yet", 2, 16'd0);
    check_q();
    tick();
    expect_("bringup_link_up", 2, 16'd1);
    expect_("bringup_state_up", 3, 16'd3);
    check_q();

    // 4. one-cycle lock drop in UP
    rx_block_lock = 1'b0;
    tick();
    expect_("drop_link_up", 2, 16'd0);
    expect_("drop_state", 3, 16'd2);
    expect_("drop_lde", 5, 16'd1);
    expect_("drop_retry", 4, 16'd0);
    check_q();

    // 2. glitch during debounce restarts the count
    base = rx_hi;
    rx_block_lock = 1'b1;
    repeat (6) tick();
    rx_block_lock = 1'b0;
    tick();
    rx_block_lock = 1'b1;
    repeat (9) tick();
    expect_("glitch_link_not_yet", 2, 16'd0);
    check_q();
    tick();
    expect_("glitch_link_up", 2, 16'd1);
    meas = rx_hi - base;
    expect_("glitch_no_rx_reset", 9, 16'd0);
    check_q();

    // 5. enable drop coincident with high BER
    enable = 1'b0; rx_high_ber = 1'b1;
    tick();
    expect_("dis_state", 3, 16'd0);
    expect_("dis_gt_reset_all", 0, 16'd1);
    expect_("dis_link_up", 2, 16'd0);
    expect_("dis_lde", 5, 16'd2);
    check_q();
    repeat (20) tick();
    expect_("dis_hold_reset", 0, 16'd1);
    expect_("dis_hold_state", 3, 16'd0);
    expect_("dis_hold_lde", 5, 16'd2);
    check_q();
    enable = 1'b1; rx_high_ber = 1'b0;
    measure("reenable_reset_width", 0, 8);
    wait_for("reenable_link_up", 2, 16'd1, 50);

    // 4b. saturation of the link-down counter
    force dut.link_down_events = 16'hFFFE;
    #1;
    release dut.link_down_events;
    rx_block_lock = 1'b0;
    tick();
    expect_("sat_reach_ffff", 5, 16'hFFFF);
    check_q();
    rx_block_lock = 1'b1;
    wait_for("sat_relink", 2, 16'd1, 50);
    rx_block_lock = 1'b0;
    tick();
    expect_("sat_hold_ffff", 5, 16'hFFFF);
    expect_("sat_state", 3, 16'd2);
    check_q();

    // 3. no lock: two RX resets then escalation
    wait_for("retry1_start", 1, 16'd1, 200);
    expect_("retry1_count", 4, 16'd1);
    check_q();
    measure("retry1_width", 1, 4);
    wait_for("retry2_start", 1, 16'd1, 200);
    expect_("retry2_count", 4, 16'd2);
    check_q();
    measure("retry2_width", 1, 4);
    expect_("escalate_state", 3, 16'd0);
    expect_("escalate_retry", 4, 16'd0);
    check_q();
    measure("escalate_reset_width", 0, 8);

    // 6. async reset in the middle of an RX reset
    wait_for("mid_rx_start", 1, 16'd1, 300);
    tick();
    rst = 1'b1;
    #1;
    expect_("arst_rx_dp", 1, 16'd0);
    expect_("arst_gt_reset_all", 0, 16'd1);
    expect_("arst_retry", 4, 16'd0);
    expect_("arst_lde", 5, 16'd0);
    expect_("arst_state", 3, 16'd0);
    expect_("arst_link_up", 2, 16'd0);
    check_q();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
